// File: rtl/led_rgb_pkg.sv
// rtl/led_rgb_pkg.sv - shared types and constants for the RGB LED driver.
// LED_RGB_ACTIVE_LOW_EN selects active-low LED pads.
package led_rgb_pkg;

  typedef enum logic [2:0] {
    OFF,
    ON_CONST,
    BLINK_ON,
    BLINK_OFF,
    HOLD
  } led_state_t;

  localparam int CNT_WIDTH_DEF = 32;

`ifdef LED_RGB_ACTIVE_LOW_EN
  localparam logic LED_OFF_LVL = 1'b1;
`else
  localparam logic LED_OFF_LVL = 1'b0;
`endif

endpackage

// File: rtl/led_rgb_if.sv
// rtl/led_rgb_if.sv - control/status bundle between register block and LED core.
interface led_rgb_if
  import led_rgb_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
  logic                 user_resetn;
  logic                 mode_r, mode_g, mode_b;
  logic                 enable_r, enable_g, enable_b;
  logic                 holded_r, holded_g, holded_b;
  logic [CNT_WIDTH-1:0] duration_r, duration_g, duration_b;
  logic                 led_r, led_g, led_b;
  logic                 led_r_sts, led_g_sts, led_b_sts;

  modport master (
    output user_resetn,
    output mode_r, mode_g, mode_b,
    output enable_r, enable_g, enable_b,
    output holded_r, holded_g, holded_b,
    output duration_r, duration_g, duration_b,
    input  led_r, led_g, led_b,
    input  led_r_sts, led_g_sts, led_b_sts
  );

  modport slave (
    input  user_resetn,
    input  mode_r, mode_g, mode_b,
    input  enable_r, enable_g, enable_b,
    input  holded_r, holded_g, holded_b,
    input  duration_r, duration_g, duration_b,
    output led_r, led_g, led_b,
    output led_r_sts, led_g_sts, led_b_sts
  );
endinterface

// File: rtl/led_rgb_channel.sv
// rtl/led_rgb_channel.sv - one LED channel: mode FSM plus blink interval counter.
module led_rgb_channel
  import led_rgb_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 enable_i,
  input  logic                 mode_i,
  input  logic                 holded_i,
  input  logic [CNT_WIDTH-1:0] duration_i,
  output logic                 level_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  led_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lvl_q, lvl_d;
  logic [CNT_WIDTH-1:0] limit;

  // Duration 0 behaves like 1, so the limit saturates at zero instead of wrapping.
  assign limit = (duration_i == '0) ? '0 : duration_i - CNT_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    if (clr_i) begin
      state_d = OFF;
      cnt_d   = '0;
      lvl_d   = 1'b0;
    end else if (!enable_i) begin
      if (holded_i) begin
        state_d = HOLD;
      end else begin
        state_d = OFF;
        cnt_d   = '0;
        lvl_d   = 1'b0;
      end
    end else if (!mode_i) begin
      state_d = ON_CONST;
      cnt_d   = '0;
      lvl_d   = 1'b1;
    end else if (state_q == BLINK_ON || state_q == BLINK_OFF) begin
      // >= so that a shortened duration toggles at once rather than waiting for a wrap.
      if (cnt_q >= limit) begin
        cnt_d   = '0;
        state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        lvl_d   = (state_q == BLINK_OFF);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      state_d = BLINK_ON;
      cnt_d   = '0;
      lvl_d   = 1'b1;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/led_rgb_core.sv
// rtl/led_rgb_core.sv - three independent LED channels with soft reset and pad polarity.
// Pad polarity follows LED_RGB_ACTIVE_LOW_EN via led_rgb_pkg::LED_OFF_LVL.
module led_rgb_core
  import led_rgb_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic      aclk,
  input logic      aresetn,
  led_rgb_if.slave bus
);

  logic clr;
  logic lvl_r, lvl_g, lvl_b;

  assign clr = ~bus.user_resetn;

  led_rgb_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_r (
    .clk_i(aclk), .rst_ni(aresetn), .clr_i(clr),
    .enable_i(bus.enable_r), .mode_i(bus.mode_r), .holded_i(bus.holded_r),
    .duration_i(bus.duration_r), .level_o(lvl_r)
  );

  led_rgb_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_g (
    .clk_i(aclk), .rst_ni(aresetn), .clr_i(clr),
    .enable_i(bus.enable_g), .mode_i(bus.mode_g), .holded_i(bus.holded_g),
    .duration_i(bus.duration_g), .level_o(lvl_g)
  );

  led_rgb_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_b (
    .clk_i(aclk), .rst_ni(aresetn), .clr_i(clr),
    .enable_i(bus.enable_b), .mode_i(bus.mode_b), .holded_i(bus.holded_b),
    .duration_i(bus.duration_b), .level_o(lvl_b)
  );

  assign bus.led_r_sts = lvl_r;
  assign bus.led_g_sts = lvl_g;
  assign bus.led_b_sts = lvl_b;
  assign bus.led_r     = lvl_r ^ LED_OFF_LVL;
  assign bus.led_g     = lvl_g ^ LED_OFF_LVL;
  assign bus.led_b     = lvl_b ^ LED_OFF_LVL;

endmodule
